sram_b_fifo_ctrl: RTL and testbench

- Streaming FIFO controller that acts as the initiator of a 1-write/1-read banked SRAM interface: write port CE0/A0/D0/WE0/WEM0, read port CE1/A1/Q1 with 1-cycle read latency.
- Converts valid/ready input and output streams into SRAM port operations and absorbs the read latency with a 2-entry output stage, giving full throughput.
- Sits between accelerator datapath stages and a 256x8 PLM bank instance.

---
 rtl/sram_b_fifo_ctrl_if.sv | 46 ++++
 rtl/sram_b_fifo_ctrl.sv | 125 ++++++++++++
 tb/tb_sram_b_fifo_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_b_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// sram_b_fifo_ctrl_if
// Bundles the two streaming handshakes, the occupancy count and the
// 1-write/1-read SRAM port of the FIFO controller.
//   master : the controller (drives in_ready, out_*, count, MEM_CE*/A*/D0/WE*)
//   slave  : the environment (producer, consumer and the SRAM macro)
// Signals:
//   in_valid/in_ready/in_data     producer stream
//   out_valid/out_ready/out_data  consumer stream
//   count                         total entries held
//   MEM_CE0/A0/D0/WE0/WEM0        SRAM write port
//   MEM_CE1/A1/Q1                 SRAM read port (Q1 one cycle after CE1)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface sram_b_fifo_ctrl_if #(
    parameter int ABITS = 8,
    parameter int DBITS = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [DBITS-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [DBITS-1:0] out_data;
    logic [ABITS+1:0] count;
    logic             MEM_CE0;
    logic [ABITS-1:0] MEM_A0;
    logic [DBITS-1:0] MEM_D0;
    logic             MEM_WE0;
    logic [DBITS-1:0] MEM_WEM0;
    logic             MEM_CE1;
    logic [ABITS-1:0] MEM_A1;
    logic [DBITS-1:0] MEM_Q1;

    modport master (
        input  in_valid, in_data, out_ready, MEM_Q1,
        output in_ready, out_valid, out_data, count,
        output MEM_CE0, MEM_A0, MEM_D0, MEM_WE0, MEM_WEM0, MEM_CE1, MEM_A1
    );

    modport slave (
        output in_valid, in_data, out_ready, MEM_Q1,
        input  in_ready, out_valid, out_data, count,
        input  MEM_CE0, MEM_A0, MEM_D0, MEM_WE0, MEM_WEM0, MEM_CE1, MEM_A1
    );
endinterface

// File: rtl/sram_b_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sram_b_fifo_ctrl
// Streaming FIFO controller in front of a 1W/1R SRAM bank with 1-cycle read
// latency. Incoming words are written straight to SRAM; reads are issued as
// soon as the 2-entry output stage can absorb the returning data, which keeps
// full throughput while never losing a word that is already in flight.
// Ports:
//   CLK    clock, rising edge
//   rst    asynchronous active-low reset
//   clear  synchronous flush (same effect as reset, one cycle)
//   bus    stream handshakes, count and SRAM port (master side)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module sram_b_fifo_ctrl #(
    parameter int ABITS = 8,
    parameter int DBITS = 8
) (
    input  logic CLK,
    input  logic rst,
    input  logic clear,
    sram_b_fifo_ctrl_if.master bus
);

    logic [ABITS-1:0] r_wptr;
    logic [ABITS-1:0] r_rptr;
    logic [ABITS:0]   r_mem_cnt;   // words in SRAM not yet read-issued
    logic             r_inflight;  // read issued at the last edge
    logic [1:0]       r_ocnt;      // output stage occupancy 0..2
    logic             r_head;      // output stage head slot index
    logic [DBITS-1:0] r_slot0;
    logic [DBITS-1:0] r_slot1;

    logic             w_in_ready;
    logic             w_wr;
    logic             w_pop;
    logic [2:0]       w_pending;
    logic             w_rd;
    logic             w_tail;

    // Handshake and read-issue decisions.
    always_comb begin
        w_in_ready = 1'b0;
        w_wr       = 1'b0;
        w_pop      = 1'b0;
        w_pending  = 3'd0;
        w_rd       = 1'b0;
        w_tail     = 1'b0;
        // mem_cnt never exceeds DEPTH, so its MSB set means exactly "full".
        w_in_ready = rst & ~clear & ~r_mem_cnt[ABITS];
        w_wr       = bus.in_valid & w_in_ready;
        w_pop      = (r_ocnt != 2'd0) & bus.out_ready & ~clear;
        // Output slots that will be committed after this edge if no read issues.
        w_pending  = {1'b0, r_ocnt} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_rd       = (r_mem_cnt != {(ABITS+1){1'b0}}) & (w_pending < 3'd2) & ~clear;
        // Tail is the slot after the head when one entry is held, else the head.
        w_tail     = r_head ^ r_ocnt[0];
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.MEM_CE0   = w_wr;
    assign bus.MEM_WE0   = w_wr;
    assign bus.MEM_A0    = r_wptr;
    assign bus.MEM_D0    = bus.in_data;
    assign bus.MEM_WEM0  = {DBITS{1'b1}};
    assign bus.MEM_CE1   = w_rd;
    assign bus.MEM_A1    = r_rptr;
    assign bus.out_valid = (r_ocnt != 2'd0);
    assign bus.out_data  = r_head ? r_slot1 : r_slot0;
    assign bus.count     = {1'b0, r_mem_cnt}
                         + {{(ABITS+1){1'b0}}, r_inflight}
                         + {{ABITS{1'b0}}, r_ocnt};

    // Pointers, SRAM occupancy, in-flight flag and output stage bookkeeping.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_wptr     <= {ABITS{1'b0}};
            r_rptr     <= {ABITS{1'b0}};
            r_mem_cnt  <= {(ABITS+1){1'b0}};
            r_inflight <= 1'b0;
            r_ocnt     <= 2'd0;
            r_head     <= 1'b0;
        end else if (clear) begin
            r_wptr     <= {ABITS{1'b0}};
            r_rptr     <= {ABITS{1'b0}};
            r_mem_cnt  <= {(ABITS+1){1'b0}};
            r_inflight <= 1'b0;
            r_ocnt     <= 2'd0;
            r_head     <= 1'b0;
        end else begin
            r_wptr     <= r_wptr + {{(ABITS-1){1'b0}}, w_wr};
            r_rptr     <= r_rptr + {{(ABITS-1){1'b0}}, w_rd};
            r_mem_cnt  <= r_mem_cnt + {{ABITS{1'b0}}, w_wr} - {{ABITS{1'b0}}, w_rd};
            r_inflight <= w_rd;
            // Capture and pop in the same cycle both apply.
            r_ocnt     <= r_ocnt + {1'b0, r_inflight} - {1'b0, w_pop};
            if (w_pop) begin
                r_head <= ~r_head;
            end else begin
                r_head <= r_head;
            end
        end
    end

    // Output stage data slots; Q1 lands in the tail slot the edge after a read.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_slot0 <= {DBITS{1'b0}};
            r_slot1 <= {DBITS{1'b0}};
        end else if (clear) begin
            // Dropping the in-flight word is done by clearing r_inflight.
            r_slot0 <= {DBITS{1'b0}};
            r_slot1 <= {DBITS{1'b0}};
        end else if (r_inflight) begin
            if (w_tail) begin
                r_slot1 <= bus.MEM_Q1;
            end else begin
                r_slot0 <= bus.MEM_Q1;
            end
        end else begin
            r_slot0 <= r_slot0;
            r_slot1 <= r_slot1;
        end
    end

endmodule

// File: tb/tb_sram_b_fifo_ctrl.sv
`timescale 1ns/1ps
module tb_sram_b_fifo_ctrl;

    logic CLK;
    logic rst;
    logic clear;

    sram_b_fifo_ctrl_if #(.ABITS(8), .DBITS(8)) bus ();

    sram_b_fifo_ctrl #(.ABITS(8), .DBITS(8)) dut (
        .CLK   (CLK),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    // 256x8 SRAM bank: synchronous write, 1-cycle registered read
    logic [7:0] sram [256];
    always @(posedge CLK) begin
        if (bus.MEM_CE0 && bus.MEM_WE0)
            sram[bus.MEM_A0] <= (sram[bus.MEM_A0] & ~bus.MEM_WEM0) | (bus.MEM_D0 & bus.MEM_WEM0);
        if (bus.MEM_CE1)
            bus.MEM_Q1 <= sram[bus.MEM_A1];
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: words accepted and not yet delivered, in order
    logic [7:0] q[$];
    int total = 0;
    int bad   = 0;
    int pops  = 0;
    bit last_acc;
    bit last_pop;
    logic [7:0] last_pop_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample before the edge, update model at the edge,
    // check occupancy after it; returns at the next falling edge.
    task automatic go();
        logic acc, pp;
        logic [7:0] d;
        #1;
        acc = bus.in_valid && bus.in_ready;
        pp  = bus.out_valid && bus.out_ready && !clear;
        d   = bus.in_data;
        check("no_addr_conflict",
              {31'd0, (bus.MEM_CE0 && bus.MEM_CE1 && (bus.MEM_A0 == bus.MEM_A1))}, 32'd0);
        if (pp)
            check("pop_data", {24'd0, bus.out_data},
                  (q.size() > 0) ? {24'd0, q[0]} : 32'hFFFF_FFFF);
        @(posedge CLK);
        last_acc = acc;
        last_pop = pp;
        if (clear) begin
            q.delete();
        end else begin
            if (pp && q.size() > 0) begin
                last_pop_data = q.pop_front();
                pops++;
            end
            if (acc) q.push_back(d);
        end
        #1;
        check("count", {22'd0, bus.count}, q.size());
        @(negedge CLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int accepted;
        bit got_first;
        logic [7:0] first;

        // ---------------- reset ----------------
        rst = 1'b0; clear = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h00; bus.out_ready = 1'b1;
        @(negedge CLK); @(negedge CLK); #1;
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_count",     {22'd0, bus.count},     32'd0);
        check("rst_ce0",       {31'd0, bus.MEM_CE0},   32'd0);
        check("rst_ce1",       {31'd0, bus.MEM_CE1},   32'd0);
        bus.in_valid = 1'b0;
        @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);

        // ---------------- single word 0x11 ----------------
        bus.in_valid = 1'b1; bus.in_data = 8'h11; bus.out_ready = 1'b1;
        #1;
        check("w_ce0",  {31'd0, bus.MEM_CE0},  32'd1);
        check("w_we0",  {31'd0, bus.MEM_WE0},  32'd1);
        check("w_a0",   {24'd0, bus.MEM_A0},   32'd0);
        check("w_d0",   {24'd0, bus.MEM_D0},   32'h11);
        check("w_wem0", {24'd0, bus.MEM_WEM0}, 32'hFF);
        check("w_ce1_empty", {31'd0, bus.MEM_CE1}, 32'd0);
        go();
        bus.in_valid = 1'b0;
        #1;
        check("r_ce1", {31'd0, bus.MEM_CE1}, 32'd1);
        check("r_a1",  {24'd0, bus.MEM_A1},  32'd0);
        check("lat_valid0", {31'd0, bus.out_valid}, 32'd0);
        go();
        check("lat_valid1", {31'd0, bus.out_valid}, 32'd0);
        go();
        check("lat_valid2", {31'd0, bus.out_valid}, 32'd1);
        check("lat_data",   {24'd0, bus.out_data},  32'h11);
        go();
        check("after_pop_valid", {31'd0, bus.out_valid}, 32'd0);

        // ---------------- full-rate stream 0x00..0xFF ----------------
        sent = 0; pops = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 259; i++) begin
            bus.in_valid = (sent < 256);
            bus.in_data  = sent[7:0];
            go();
            if (last_acc) sent++;
        end
        check("stream_sent", sent, 32'd256);
        check("stream_pops", pops, 32'd256);

        // ---------------- fill to full with out_ready=0 ----------------
        accepted = 0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.in_data = 8'($urandom);
            go();
            if (last_acc) accepted++;
        end
        check("full_accepted", accepted, 32'd258);
        check("full_count",    {22'd0, bus.count},    32'd258);
        check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        #1;
        check("full_pop_issues_rd", {31'd0, bus.MEM_CE1}, 32'd1);
        go();
        bus.out_ready = 1'b0;
        #1;
        check("full_in_ready_rise", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 400 && q.size() > 0; i++) go();
        check("full_drained", q.size(), 32'd0);

        // ---------------- random rates, pointer wrap ----------------
        sent = 0;
        for (int i = 0; i < 3000 && (sent < 300 || q.size() > 0); i++) begin
            bus.in_valid  = (sent < 300) && ($urandom_range(0, 1) == 1);
            bus.in_data   = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            go();
            if (last_acc) sent++;
        end
        check("rand_sent",  sent,     32'd300);
        check("rand_empty", q.size(), 32'd0);

        // ---------------- out_ready toggling each cycle ----------------
        pops = 0;
        for (int i = 0; i < 200; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = 8'($urandom);
            bus.out_ready = i[0];
            go();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 400 && q.size() > 0; i++) go();
        check("toggle_empty", q.size(), 32'd0);
        check("toggle_pops",  pops,     32'd200);

        // ---------------- clear with a read in flight ----------------
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = 8'h30 + 8'(i);
            go();
        end
        bus.out_ready = 1'b1; bus.in_data = 8'h77;
        #1;
        check("clr_pre_rd", {31'd0, bus.MEM_CE1}, 32'd1);
        go();
        check("clr_pre_count", {22'd0, bus.count}, 32'd5);
        clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h99;
        #1;
        check("clr_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("clr_ce0",      {31'd0, bus.MEM_CE0},  32'd0);
        check("clr_ce1",      {31'd0, bus.MEM_CE1},  32'd0);
        go();
        clear = 1'b0; bus.in_valid = 1'b0;
        check("clr_count",  {22'd0, bus.count},     32'd0);
        check("clr_valid0", {31'd0, bus.out_valid}, 32'd0);
        go();
        check("clr_valid1", {31'd0, bus.out_valid}, 32'd0);
        go();
        check("clr_valid2", {31'd0, bus.out_valid}, 32'd0);
        bus.in_valid = 1'b1; bus.in_data = 8'hA5;
        go();
        bus.in_valid = 1'b0;
        got_first = 1'b0; first = 8'h00;
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            go();
            if (last_pop && !got_first) begin
                first = last_pop_data;
                got_first = 1'b1;
            end
        end
        check("clr_first_seen", {31'd0, got_first}, 32'd1);
        check("clr_first_data", {24'd0, first},     32'hA5);
        check("clr_final_empty", {31'd0, bus.out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
